mul_cell_share_sched: RTL and testbench
=======================================

// Module: mul_cell_share_sched
// PURPOSE
//  Round-robin scheduler sharing one pipelined 32x32->32 (low word) multiply cell among
//  NUM_REQ requesters. Accepts operands over valid/ready, issues one op per cycle into the
//  cell, and tracks a tag pipeline matched to the cell latency to route each result back.
//  Sits between custom-instruction/accelerator masters and the single multiply cell instance.
// PARAMETERS
//  NUM_REQ      2  number of requesters, 1..8
//  MUL_LATENCY  1  clocks from mul_src* change to valid mul_result, 1..4 (cell reg stages)
// PORTS
//  clk          in   1            system clock
//  reset        in   1            async reset, active-high
//  sched_en     in   1            1: grants allowed; 0: no new grants, in-flight ops drain
//  req_valid    in   NUM_REQ      per-requester operand valid
//  req_ready    out  NUM_REQ      one-hot grant (combinational from req_valid, ptr, sched_en)
//  req_src1     in   32*NUM_REQ   operand A, requester i at [32*i+31:32*i]
//  req_src2     in   32*NUM_REQ   operand B, same packing
//  mul_src1     out  32           registered operand A to cell
//  mul_src2     out  32           registered operand B to cell
//  mul_result   in   32           cell result, low 32 bits of product
//  rsp_valid    out  NUM_REQ      one-hot, 1-cycle pulse: result for requester i
//  rsp_result   out  32           registered result, valid when any rsp_valid bit set
//  busy         out  1            1 while any op is in issue reg or tag pipeline
// BEHAVIOUR
//  - Reset: req_ready=0, mul_src1/2=0, rsp_valid=0, rsp_result=0, busy=0, rr ptr=0,
//    all tag-pipe valid bits 0. Reset mid-operation drops in-flight ops; no rsp emitted.
//  - Arbitration: each cycle, if sched_en, grant first i with req_valid[i], searching from
//    ptr upward with wrap (ptr..NUM_REQ-1,0..ptr-1). At most one req_ready bit high.
//    On accept (valid&ready at edge) ptr <= grant+1 mod NUM_REQ; else ptr holds.
//  - No response backpressure; fixed latency, so one accept per cycle (full throughput),
//    same requester may be granted back-to-back if it is the only one valid.
//  - Issue stage: on accept, mul_src1/2 <= granted operands, tag {valid,id} enters stage 0.
//    With no accept, mul_src1/2 hold value, stage-0 valid <= 0.
//  - Tag pipe: MUL_LATENCY stages behind issue. When last stage valid:
//    rsp_result <= mul_result, rsp_valid <= onehot(id) for one cycle; else rsp_valid <= 0,
//    rsp_result holds.
//  - Latency: accept at edge E -> rsp_valid high in cycle after edge E+MUL_LATENCY+1
//    (2 cycles after accept for default). Responses per requester in accept order.
//  - busy = OR of issue/tag valid bits (registered view; 0 same cycle rsp pulse is last).
//  - sched_en falling: no grant that cycle; pipeline continues, busy falls after drain.
//  - Arithmetic: product mod 2^32; unsigned/signed identical for low word; no overflow flag.
//  - NUM_REQ=1: ptr constant 0, req_ready = req_valid & sched_en.
// CONFIGURATION
//  MUL_SCHED_PERF_EN defined: adds outputs perf_ops[31:0] (accepted ops) and
//   perf_stall[31:0] (cycles any req_valid high but no accept); both wrap at 2^32,
//   reset to 0, increment by 1 max per cycle.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Single op: req0 A=0x0001_0003, B=0x0000_0005, cell model latency 1 -> rsp_valid=01
//    two cycles after accept, rsp_result=0x0005_000F; busy 1 then 0.
//  2 Contention: req0,req1 valid every cycle -> grants alternate 0,1,0,1; rsp_valid order
//    matches; perf_ops=N after N accepts (PERF_EN).
//  3 Wrap: NUM_REQ=4, only req3 and req0 valid, ptr=3 -> grants 3,0,3,0; results correct
//    for A=0xFFFF_FFFF,B=0x2 -> 0xFFFF_FFFE.
//  4 sched_en=0 with 3 ops in flight -> no req_ready, all 3 rsp still delivered, busy clears;
//    perf_stall counts each blocked cycle.
//  5 Reset asserted between accept and rsp -> no rsp_valid ever for that op, all outputs 0,
//    first grant after release goes to req0.
//  6 MUL_LATENCY=3 with cell model delay 3 -> back-to-back 8 ops, each rsp 4 cycles after
//    accept, throughput 1/cycle, random operands checked vs (A*B)&0xFFFFFFFF.

Source files
------------

// File: rtl/mul_cell_share_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : mul_cell_share_sched
// Brief  : Round-robin sharing of one pipelined 32x32 low-word multiply cell,
//          with a tag pipe matched to the cell latency for result routing.
//          Optional perf counters when MUL_SCHED_PERF_EN is defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module mul_cell_share_sched #(
    parameter int NUM_REQ     = 2,
    parameter int MUL_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sched_en,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_src1,
    input  logic [32*NUM_REQ-1:0]  req_src2,
    output logic [31:0]            mul_src1,
    output logic [31:0]            mul_src2,
    input  logic [31:0]            mul_result,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_result,
    output logic                   busy
`ifdef MUL_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_ops,
    output logic [31:0]            perf_stall
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]                   ptr_q, ptr_d;
    logic [31:0]                        mul_src1_q, mul_src1_d;
    logic [31:0]                        mul_src2_q, mul_src2_d;
    logic [MUL_LATENCY:0]               tag_v_q, tag_v_d;
    logic [MUL_LATENCY:0][PTR_W-1:0]    tag_id_q, tag_id_d;
    logic [NUM_REQ-1:0]                 rsp_valid_q, rsp_valid_d;
    logic [31:0]                        rsp_result_q, rsp_result_d;

    logic [NUM_REQ-1:0]                 w_grant;
    logic [PTR_W-1:0]                   w_grant_idx;
    logic                               w_found;

    // Rotating priority search starting at ptr; the first hit wins.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && sched_en && !reset && req_valid[i] &&
                    (((int'(ptr_q) + k) % NUM_REQ) == i)) begin
                    w_found     = 1'b1;
                    w_grant_idx = PTR_W'(i);
                    w_grant[i]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        mul_src1_d = mul_src1_q;
        mul_src2_d = mul_src2_q;
        tag_v_d    = '0;
        tag_id_d   = tag_id_q;
        if (w_found) begin
            ptr_d = PTR_W'((int'(w_grant_idx) + 1) % NUM_REQ);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                mul_src1_d = req_src1[32*i +: 32];
                mul_src2_d = req_src2[32*i +: 32];
            end
        end
        tag_v_d[0]  = w_found;
        tag_id_d[0] = w_grant_idx;
        for (int s = 1; s <= MUL_LATENCY; s++) begin
            tag_v_d[s]  = tag_v_q[s-1];
            tag_id_d[s] = tag_id_q[s-1];
        end
    end

    // The last tag stage lines up with the cycle the cell result is valid.
    always_comb begin
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        if (tag_v_q[MUL_LATENCY]) begin
            rsp_result_d = mul_result;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid_d[i] = (tag_id_q[MUL_LATENCY] == PTR_W'(i));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= '0;
            mul_src1_q   <= '0;
            mul_src2_q   <= '0;
            tag_v_q      <= '0;
            tag_id_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            mul_src1_q   <= mul_src1_d;
            mul_src2_q   <= mul_src2_d;
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign req_ready  = w_grant;
    assign mul_src1   = mul_src1_q;
    assign mul_src2   = mul_src2_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign busy       = |tag_v_q;

`ifdef MUL_SCHED_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_ops_d   = perf_ops_q + {31'd0, w_found};
        perf_stall_d = perf_stall_q + {31'd0, (|req_valid) & ~w_found};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_cell_share_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_mul_cell_share_sched
// Brief  : Self-checking bench for mul_cell_share_sched (4 requesters, 3-stage
//          cell) against a queue-based reference model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mul_cell_share_sched;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              sched_en;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_src1;
    logic [32*N-1:0]   req_src2;
    logic [31:0]       mul_src1;
    logic [31:0]       mul_src2;
    logic [31:0]       mul_result;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_result;
    logic              busy;
`ifdef MUL_SCHED_PERF_EN
    logic [31:0]       perf_ops;
    logic [31:0]       perf_stall;
`endif

    mul_cell_share_sched #(
        .NUM_REQ     (N),
        .MUL_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sched_en   (sched_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .mul_src1   (mul_src1),
        .mul_src2   (mul_src2),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .busy       (busy)
`ifdef MUL_SCHED_PERF_EN
        ,
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Multiply cell: LAT register stages from operands to low-word product.
    logic [31:0] cell_q [LAT];
    always @(posedge clk) begin
        cell_q[0] <= mul_src1 * mul_src2;
        for (int k = 1; k < LAT; k++) cell_q[k] <= cell_q[k-1];
    end
    assign mul_result = cell_q[LAT-1];

    // Reference model: outstanding results keyed by the cycle they must appear.
    typedef struct {
        int          due;
        int          id;
        logic [31:0] prod;
    } pend_t;

    pend_t       q[$];
    int          cyc;
    int          ptr_m;
    int          n_vec;
    int          n_err;
    logic [31:0] ops_m;
    logic [31:0] stall_m;

    typedef struct {
        logic        en;
        logic [N-1:0] v;
        logic [31:0] a;
        logic [31:0] b;
        logic [N-1:0] exp_rdy;
    } vec_t;

    vec_t tbl[21];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic bit_at(input logic [N-1:0] v, input int idx);
        logic [N-1:0] t;
        t = v >> idx;
        return t[0];
    endfunction

    task automatic check_after_edge();
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(N'(1) << q[0].id));
            chk("rsp_result", rsp_result, q[0].prod);
            void'(q.pop_front());
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
        chk("busy", 32'(busy), 32'(q.size() > 0));
`ifdef MUL_SCHED_PERF_EN
        chk("perf_ops", perf_ops, ops_m);
        chk("perf_stall", perf_stall, stall_m);
`endif
    endtask

    // One clock: drive, check grant, advance model at the edge, check outputs.
    task automatic step(input logic en, input logic [N-1:0] v,
                        input logic use_tbl, input logic [N-1:0] tbl_rdy);
        int          g;
        logic [31:0] a;
        logic [31:0] b;
        logic [N-1:0] exp_rdy;
        sched_en  = en;
        req_valid = v;
        #1;
        g = -1;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && bit_at(v, (ptr_m + k) % N)) g = (ptr_m + k) % N;
            end
        end
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (use_tbl) chk("req_ready_tbl", 32'(req_ready), 32'(tbl_rdy));
        a = '0;
        b = '0;
        if (g >= 0) begin
            a = 32'(req_src1 >> (32 * g));
            b = 32'(req_src2 >> (32 * g));
        end
        @(posedge clk);
        cyc++;
        if (g >= 0) begin
            q.push_back('{due: cyc + LAT + 1, id: g, prod: a * b});
            ptr_m = (g + 1) % N;
            ops_m++;
        end else if (v != '0) begin
            stall_m++;
        end
        #1;
        if (g >= 0) begin
            chk("mul_src1", mul_src1, a);
            chk("mul_src2", mul_src2, b);
        end
        check_after_edge();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        req_valid = '1;
        sched_en  = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mul_src1", mul_src1, 32'd0);
        chk("rst_mul_src2", mul_src2, 32'd0);
`ifdef MUL_SCHED_PERF_EN
        chk("rst_perf_ops", perf_ops, 32'd0);
        chk("rst_perf_stall", perf_stall, 32'd0);
`endif
        req_valid = '0;
        sched_en  = 1'b0;
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < N; i++) begin
            req_src1[32*i +: 32] = $urandom();
            req_src2[32*i +: 32] = $urandom();
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
        ptr_m     = 0;
        ops_m     = '0;
        stall_m   = '0;
        reset     = 1'b1;
        sched_en  = 1'b0;
        req_valid = '0;
        req_src1  = '0;
        req_src2  = '0;

        //            en    v        a             b             expected grant
        tbl[0]  = '{1'b1, 4'b0001, 32'h0001_0003, 32'h0000_0005, 4'b0001};
        tbl[1]  = '{1'b1, 4'b0000, 32'h0,         32'h0,         4'b0000};
        tbl[2]  = '{1'b1, 4'b0000, 32'h0,         32'h0,         4'b0000};
        tbl[3]  = '{1'b1, 4'b0000, 32'h0,         32'h0,         4'b0000};
        tbl[4]  = '{1'b1, 4'b0000, 32'h0,         32'h0,         4'b0000};
        tbl[5]  = '{1'b1, 4'b0011, 32'h0000_1234, 32'h0000_0011, 4'b0010};
        tbl[6]  = '{1'b1, 4'b0011, 32'h8000_0001, 32'h0000_0003, 4'b0001};
        tbl[7]  = '{1'b1, 4'b0011, 32'h0000_ffff, 32'h0001_0001, 4'b0010};
        tbl[8]  = '{1'b1, 4'b0011, 32'h1234_5678, 32'h9abc_def0, 4'b0001};
        tbl[9]  = '{1'b1, 4'b1001, 32'hffff_ffff, 32'h0000_0002, 4'b1000};
        tbl[10] = '{1'b1, 4'b1001, 32'hffff_ffff, 32'h0000_0002, 4'b0001};
        tbl[11] = '{1'b1, 4'b1001, 32'hffff_ffff, 32'h0000_0002, 4'b1000};
        tbl[12] = '{1'b1, 4'b1001, 32'hffff_ffff, 32'h0000_0002, 4'b0001};
        tbl[13] = '{1'b0, 4'b1111, 32'h0000_0007, 32'h0000_0009, 4'b0000};
        tbl[14] = '{1'b0, 4'b1111, 32'h0000_0007, 32'h0000_0009, 4'b0000};
        tbl[15] = '{1'b0, 4'b1111, 32'h0000_0007, 32'h0000_0009, 4'b0000};
        tbl[16] = '{1'b0, 4'b1111, 32'h0000_0007, 32'h0000_0009, 4'b0000};
        tbl[17] = '{1'b0, 4'b1111, 32'h0000_0007, 32'h0000_0009, 4'b0000};
        tbl[18] = '{1'b1, 4'b0100, 32'h0000_0100, 32'h0000_0100, 4'b0100};
        tbl[19] = '{1'b1, 4'b1111, 32'hdead_beef, 32'h0000_0010, 4'b1000};
        tbl[20] = '{1'b1, 4'b0000, 32'h0,         32'h0,         4'b0000};

        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            req_src1 = {N{tbl[i].a}};
            req_src2 = {N{tbl[i].b}};
            step(tbl[i].en, tbl[i].v, 1'b1, tbl[i].exp_rdy);
            if (i == 4) chk("single_op_result", rsp_result, 32'h0005_000F);
        end
        repeat (LAT + 2) step(1'b1, '0, 1'b0, '0);

        // Reset while an op is in flight: it must vanish and ptr must restart at 0.
        randomize_operands();
        step(1'b1, 4'b0010, 1'b0, '0);
        step(1'b1, 4'b0000, 1'b0, '0);
        reset = 1'b1;
        q.delete();
        ptr_m   = 0;
        ops_m   = '0;
        stall_m = '0;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step(1'b1, 4'b1111, 1'b1, 4'b0001);
        repeat (LAT + 3) step(1'b1, '0, 1'b0, '0);

        // Random traffic with occasional scheduler disable.
        for (int t = 0; t < 400; t++) begin
            randomize_operands();
            step(($urandom_range(0, 9) != 0), N'($urandom()), 1'b0, '0);
        end
        repeat (LAT + 2) step(1'b1, '0, 1'b0, '0);

        // Eight back-to-back ops from a single requester.
        for (int t = 0; t < 8; t++) begin
            randomize_operands();
            step(1'b1, 4'b0100, 1'b0, '0);
        end
        repeat (LAT + 2) step(1'b1, '0, 1'b0, '0);

        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
